// File: rtl/flatten_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flatten_pkg
//  Description : Constants and types shared by the flatten buffer and the
//                fully-connected layer it feeds (feature width, frame size,
//                feature word type, flatten FSM state encoding).
//  Revision    : 1.0  initial release
// ============================================================================
package flatten_pkg;

    localparam int DATA_W   = 22;
    localparam int NUM_FEAT = 225;

    typedef logic signed [DATA_W-1:0] feature_t;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_FC = 2'd2
    } state_t;

endpackage : flatten_pkg
`default_nettype wire

// File: rtl/flatten_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : flatten_buffer_if
//  Description : Bundle between the pooling stream, the flatten buffer and
//                the FC layer.
//                  i_valid / i_data / i_sof / o_ready : serial feature stream
//                  o_flattened_data                   : stored frame, parallel
//                  o_start                            : frame-ready pulse
//                  i_fc_done                          : FC result valid
//                  o_busy / o_drop / o_timeout        : status
//                Modport slave is the buffer; master is the environment that
//                drives the stream and the FC handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface flatten_buffer_if;
    import flatten_pkg::*;

    logic     i_valid;
    feature_t i_data;
    logic     i_sof;
    logic     o_ready;
    feature_t o_flattened_data [0:NUM_FEAT-1];
    logic     o_start;
    logic     i_fc_done;
    logic     o_busy;
    logic     o_drop;
    logic     o_timeout;

    modport master (
        output i_valid, i_data, i_sof, i_fc_done,
        input  o_ready, o_flattened_data, o_start, o_busy, o_drop, o_timeout
    );

    modport slave (
        input  i_valid, i_data, i_sof, i_fc_done,
        output o_ready, o_flattened_data, o_start, o_busy, o_drop, o_timeout
    );

endinterface : flatten_buffer_if
`default_nettype wire

// File: rtl/flatten_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : flatten_buffer
//  Description : Collects a raster-order stream of NUM_FEAT signed features
//                into a register array, presents it in parallel, pulses
//                o_start once the frame is complete, then holds the array
//                frozen until the FC layer signals i_fc_done (or TIMEOUT_CYC
//                cycles elapse) before accepting the next frame.
//  Ports       : clk  - system clock (posedge)
//                rst  - synchronous reset, active low
//                bus  - flatten_buffer_if.slave (stream, array, handshake,
//                       status pulses)
//  Revision    : 1.0  initial release
// ============================================================================
module flatten_buffer
    import flatten_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic       clk,
    input  wire logic       rst,
    flatten_buffer_if.slave bus
);

    localparam int C_PTR_W = $clog2(NUM_FEAT);
    localparam int C_TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [C_PTR_W-1:0] C_LAST_IDX = C_PTR_W'(NUM_FEAT - 1);
    localparam logic [C_TO_W-1:0]  C_TO_LAST  = C_TO_W'(TIMEOUT_CYC - 1);

    state_t              r_state;
    logic [C_PTR_W-1:0]  r_wr_ptr;
    logic [C_TO_W-1:0]   r_to_cnt;
    feature_t            r_mem [0:NUM_FEAT-1];

    logic                r_ready;
    logic                r_start;
    logic                r_busy;
    logic                r_drop;
    logic                r_timeout;

    logic                w_accept;
    logic [C_PTR_W-1:0]  w_idx;
    logic                w_last;

    // r_ready is only ever high in FILL, so an accepted beat implies FILL.
    assign w_accept = bus.i_valid & r_ready;
    // A start-of-frame beat always lands at index 0, abandoning any partial
    // frame; older entries are simply overwritten by the new frame later.
    assign w_idx    = bus.i_sof ? '0 : r_wr_ptr;
    assign w_last   = (w_idx == C_LAST_IDX);

    // ------------------------------------------------------------------
    // Storage array: written only by accepted beats.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FEAT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            r_mem[w_idx] <= bus.i_data;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= FILL;
            r_wr_ptr  <= '0;
            r_to_cnt  <= '0;
            r_ready   <= 1'b1;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            // Any beat offered while closed is lost; flag it the next cycle.
            r_drop    <= bus.i_valid & ~r_ready;

            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_wr_ptr <= '0;
                            r_state  <= ISSUE;
                            r_ready  <= 1'b0;
                            r_start  <= 1'b1;
                            r_busy   <= 1'b1;
                        end else begin
                            r_wr_ptr <= w_idx + 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    r_state  <= WAIT_FC;
                    r_to_cnt <= '0;
                end

                WAIT_FC: begin
                    if (bus.i_fc_done) begin
                        r_state <= FILL;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_to_cnt == C_TO_LAST) begin
                        // TIMEOUT_CYC full cycles spent waiting: give up.
                        r_state   <= FILL;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state  <= FILL;
                    r_wr_ptr <= '0;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready   = r_ready;
    assign bus.o_start   = r_start;
    assign bus.o_busy    = r_busy;
    assign bus.o_drop    = r_drop;
    assign bus.o_timeout = r_timeout;

    for (genvar g = 0; g < NUM_FEAT; g++) begin : g_flat
        assign bus.o_flattened_data[g] = r_mem[g];
    end

endmodule : flatten_buffer
`default_nettype wire

// File: tb/tb_flatten_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flatten_buffer
//  Description : Self-checking bench for flatten_buffer. A stimulus process
//                drives directed and random streams; a reference model,
//                clocked on the rising edge, tracks the frame contents and
//                the locked window after each completed frame and queues the
//                expected o_start / o_drop / o_timeout cycles; a monitor on
//                the falling edge compares the DUT against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flatten_buffer;
    import flatten_pkg::*;

    localparam int TIMEOUT_CYC = 1024;
    localparam int FRAME_W     = NUM_FEAT * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flatten_buffer_if bus ();

    flatten_buffer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              cyc      = 0;
    bit              model_on = 1'b0;
    bit              m_locked = 1'b0;
    int              m_lock_t = 0;
    int              m_cnt    = 0;
    feature_t        m_mem [0:NUM_FEAT-1];
    int              start_q [$];
    logic [FRAME_W-1:0] frame_q [$];
    int              drop_q [$];
    int              to_q [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a frame of NUM_FEAT accepted beats locks the buffer;
    // start is expected in the cycle after the last beat (T); fc_done is
    // honoured from cycle T+1 on; with no fc_done the lock ends after
    // TIMEOUT_CYC waiting cycles and a timeout pulse follows.
    // ------------------------------------------------------------------
    initial begin : model_p
        int idx;
        logic [FRAME_W-1:0] snap;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst === 1'b0) begin
                model_on = 1'b1;
                m_locked = 1'b0;
                m_cnt    = 0;
                for (int i = 0; i < NUM_FEAT; i++) m_mem[i] = '0;
                start_q.delete();
                frame_q.delete();
                drop_q.delete();
                to_q.delete();
            end else if (model_on) begin
                if (m_locked) begin
                    if (bus.i_valid === 1'b1) drop_q.push_back(cyc);
                    if (bus.i_fc_done === 1'b1 && (cyc - 1) >= m_lock_t + 1) begin
                        m_locked = 1'b0;
                    end else if ((cyc - 1) == m_lock_t + TIMEOUT_CYC) begin
                        m_locked = 1'b0;
                        to_q.push_back(cyc);
                    end
                end else if (bus.i_valid === 1'b1) begin
                    idx = (bus.i_sof === 1'b1) ? 0 : m_cnt;
                    m_mem[idx] = bus.i_data;
                    m_cnt = idx + 1;
                    if (m_cnt == NUM_FEAT) begin
                        m_cnt    = 0;
                        m_locked = 1'b1;
                        m_lock_t = cyc;
                        for (int i = 0; i < NUM_FEAT; i++) snap[i*DATA_W +: DATA_W] = m_mem[i];
                        start_q.push_back(cyc);
                        frame_q.push_back(snap);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor_p
        bit exp;
        int n;
        logic [FRAME_W-1:0] fr;
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("ready", 64'(bus.o_ready), 64'(!m_locked));
                check("busy",  64'(bus.o_busy),  64'(m_locked));

                exp = (start_q.size() > 0 && start_q[0] == cyc);
                check("start", 64'(bus.o_start), 64'(exp));
                if (exp) begin
                    void'(start_q.pop_front());
                    fr = frame_q.pop_front();
                    n = 0;
                    for (int i = 0; i < NUM_FEAT; i++)
                        if (bus.o_flattened_data[i] !== fr[i*DATA_W +: DATA_W]) n++;
                    check("start_frame_mismatches", 64'(n), 64'd0);
                end

                exp = (drop_q.size() > 0 && drop_q[0] == cyc);
                if (exp) void'(drop_q.pop_front());
                check("drop", 64'(bus.o_drop), 64'(exp));

                exp = (to_q.size() > 0 && to_q[0] == cyc);
                if (exp) void'(to_q.pop_front());
                check("timeout", 64'(bus.o_timeout), 64'(exp));

                n = 0;
                for (int i = 0; i < NUM_FEAT; i++)
                    if (bus.o_flattened_data[i] !== m_mem[i]) n++;
                check("array_mismatches", 64'(n), 64'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input feature_t d, input bit s);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_sof   = s;
        tick();
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic fc_pulse();
        bus.i_fc_done = 1'b1;
        tick();
        bus.i_fc_done = 1'b0;
    endtask

    initial begin : watchdog_p
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim_p
        bus.i_valid   = 1'b0;
        bus.i_data    = '0;
        bus.i_sof     = 1'b0;
        bus.i_fc_done = 1'b0;
        rst           = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        idle(2);

        // Fill and issue with i_data = k, then back-pressure drops.
        for (int k = 0; k < NUM_FEAT; k++) beat(feature_t'(k), k == 0);
        repeat (6) beat(feature_t'(22'h3FFFFF), 1'b0);
        beat(feature_t'(22'h3FFFFF), 1'b1);
        idle(1);
        fc_pulse();
        idle(3);

        // Frame restart via sof.
        for (int k = 0; k < 100; k++) beat(feature_t'(5), 1'b0);
        beat(feature_t'(-7), 1'b1);
        for (int k = 0; k < NUM_FEAT - 1; k++) beat(feature_t'(3), 1'b0);
        idle($urandom_range(2, 20));
        fc_pulse();
        idle(2);

        // Timeout: fc_done during the issue cycle must be ignored.
        for (int k = 0; k < NUM_FEAT; k++) beat(feature_t'($urandom), k == 0);
        bus.i_valid   = 1'b0;
        bus.i_fc_done = 1'b1;
        tick();
        bus.i_fc_done = 1'b0;
        idle(TIMEOUT_CYC + 40);
        repeat (3) beat(feature_t'($urandom), 1'b0);
        for (int k = 0; k < NUM_FEAT; k++) beat(feature_t'($urandom), k == 0);
        idle(5);
        fc_pulse();
        idle(2);

        // Random traffic; fc_done arrives at random, including during FILL.
        for (int c = 0; c < 4000; c++) begin
            bus.i_valid   = ($urandom_range(0, 3) != 0);
            bus.i_data    = feature_t'($urandom);
            bus.i_sof     = ($urandom_range(0, 399) == 0);
            bus.i_fc_done = ($urandom_range(0, 29) == 0);
            tick();
        end
        bus.i_fc_done = 1'b0;
        idle(TIMEOUT_CYC + 10);

        // Reset mid-fill, then a frame without sof.
        for (int k = 0; k < 50; k++) beat(feature_t'($urandom), k == 0);
        bus.i_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < NUM_FEAT; k++) beat(feature_t'($urandom), 1'b0);
        idle(4);
        fc_pulse();
        idle(5);

        check("start_queue_drained", 64'(start_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_flatten_buffer
`default_nettype wire

// File: doc/flatten_buffer.md
Name: flatten_buffer

Overview:
- Producer side of the fully-connected layer's input interface.
- Collects the serial feature stream from the pooling stage (15x15 = 225 signed 22-bit values, raster order) into a register array.
- Presents the array in parallel on o_flattened_data and issues a single-cycle start pulse.
- Holds the array frozen until the FC layer reports its result, then reopens for the next frame.

Parameters:
- DATA_W, 22, feature word width (signed).
- NUM_FEAT, 225, features per frame; index range 0..NUM_FEAT-1.
- TIMEOUT_CYC, 1024, maximum cycles to wait for i_fc_done before abandoning the frame.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- i_valid  input  1  feature beat present on i_data.
- i_data  input  DATA_W signed  feature value.
- i_sof  input  1  qualifies the current beat as element 0 of a frame; meaningful only with i_valid.
- o_ready  output  1  buffer accepts beats; a beat transfers on i_valid & o_ready.
- o_flattened_data  output  DATA_W signed x [0:NUM_FEAT-1]  stored frame, driven directly from the storage registers.
- o_start  output  1  one-cycle pulse; frame complete and stable.
- i_fc_done  input  1  FC result valid; connects to the FC layer's o_result_valid.
- o_busy  output  1  high in ISSUE and WAIT_FC.
- o_drop  output  1  one-cycle pulse when a beat has i_valid=1 and o_ready=0.
- o_timeout  output  1  one-cycle pulse when the FC wait is abandoned.

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to FILL and wr_ptr to 0.
  - All storage registers clear to 0.
  - o_start, o_drop and o_timeout go to 0; o_busy goes to 0.
  - o_ready is 1 in the first cycle after reset release.
- FSM states: FILL, ISSUE, WAIT_FC.
- FILL:
  - o_ready=1.
  - On an accepted beat, mem[wr_ptr] <= i_data and wr_ptr increments.
  - An accepted beat with i_sof=1 writes mem[0] and sets wr_ptr=1, discarding any partial frame. The previously written entries are not cleared.
  - An accepted beat with i_sof=0 while wr_ptr=0 is still stored at index 0; sof is not mandatory.
  - When the beat at index NUM_FEAT-1 is accepted, the next state is ISSUE and wr_ptr resets to 0.
- ISSUE:
  - Lasts exactly one cycle with o_start=1 and o_ready=0.
  - Next state is WAIT_FC.
  - Latency: the last beat is accepted at edge T, o_start is high in cycle T+1, and the array holds final values from edge T.
- WAIT_FC:
  - o_ready=0 and the array is frozen.
  - On i_fc_done=1, go to FILL; o_ready is 1 the following cycle.
  - If TIMEOUT_CYC cycles elapse without i_fc_done, pulse o_timeout for one cycle and go to FILL.
  - i_fc_done outside WAIT_FC is ignored.
- Start spacing: o_start is low for at least one cycle between pulses, as required by the FC layer's rising-edge detection.
- Drops: a beat with i_valid=1 while o_ready=0 is not stored and pulses o_drop; this includes a beat carrying i_sof.
- Array stability: o_flattened_data changes only on accepted beats, and therefore only in FILL.
- Arithmetic:
  - wr_ptr width is $clog2(NUM_FEAT).
  - The timeout counter width is $clog2(TIMEOUT_CYC+1); it clears on entry to WAIT_FC.
  - Data is stored without any arithmetic or sign change.
- Reset mid-operation: reset from any state returns to FILL with the buffer cleared and no pulse emitted.

Decomposition:
- Shared package flatten_pkg holds:
  - DATA_W and NUM_FEAT constants, shared with Fully_Connected_Layer;
  - the state enum typedef {FILL, ISSUE, WAIT_FC};
  - a feature_t typedef (logic signed [DATA_W-1:0]).
- No sub-module is needed. The storage array, pointer, FSM and timeout counter sit in one module of roughly 150–200 lines.

Test Plan:
- Fill and issue:
  - Stimulus: reset, then stream 225 beats with i_data=k (k=0..224), i_sof on k=0.
  - Required: o_start pulses exactly once, one cycle after beat 224; o_flattened_data[k]=k; o_busy=1.
- Back-pressure and drop:
  - Stimulus: after o_start, drive i_valid with i_data=22'h3FFFFF.
  - Required: o_drop pulses each such cycle; the array is unchanged.
  - Stimulus: then pulse i_fc_done.
  - Required: o_ready=1 on the next cycle.
- Frame restart:
  - Stimulus: stream 100 beats of value 5, then assert i_sof with value -7, then 224 beats of value 3.
  - Required: o_start follows the last beat; mem[0]=-7, mem[1..224]=3.
- Timeout:
  - Stimulus: complete a frame and never assert i_fc_done.
  - Required: o_timeout pulses 1024 cycles after entry to WAIT_FC; state returns to FILL; no second o_start occurs.
- Reset mid-fill:
  - Stimulus: after 50 beats, drive rst=0 for one cycle, then stream 225 beats.
  - Required: o_start after beat 225 of the new stream; mem[0] holds the first post-reset value.
- Integration:
  - Stimulus: connect to Fully_Connected_Layer with all weights 1 and features 1.
  - Required: FC o_result_data=225, and its o_result_valid returns flatten_buffer to FILL.
